reset_seq_gen: RTL and testbench

// - Parametrised multi-channel reset sequencer: one clock, N_CH active-low reset outputs.
// - Outputs are held until the clock generator reports lock, then released one channel at
//   a time, in index order, with programmable spacing.
// - Per-channel soft-reset requests re-reset channel k and every channel above it.
// - Loss of lock re-resets all channels.
// - Sits beside the clock generator. Drives the PHY, AXI-Lite and datapath FIFO resets

---
 rtl/reset_seq_gen.sv | 166 ++++++++++++++++
 tb/tb_reset_seq_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/reset_seq_gen.sv
// Multi-channel reset sequencer: holds N_CH active-low resets until lock, then releases
// them in index order with programmable spacing; soft requests and lock loss re-reset.
module reset_seq_gen #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYC    = 64,
  parameter int STEP_CYC    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            g_resetn,
  input  logic            locked,
  input  logic [N_CH-1:0] soft_rst,
  output logic [N_CH-1:0] rst_n_out,
  output logic            seq_done,
  output logic [1:0]      state_o
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                         state, state_n;
  logic [CNT_W-1:0]               cnt, cnt_n;
  logic [IDX_W-1:0]               idx, idx_n, idx_inc, low_k;
  logic [N_CH-1:0]                rst_n_n, clr_mask;
  logic                           done_n;
  logic [1:0]                     rst_sync;
  logic                           rst_n;
  logic [SYNC_STAGES-1:0]         lock_pipe;
  logic [SYNC_STAGES-1:0][N_CH-1:0] soft_pipe;
  logic                           locked_s;
  logic [N_CH-1:0]                soft_rst_s;

  // Local reset asserts with g_resetn but releases two edges later.
  always_ff @(posedge clk or negedge g_resetn) begin
    if (!g_resetn) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_pipe <= '0;
      soft_pipe <= '0;
    end else begin
      lock_pipe <= {lock_pipe[SYNC_STAGES-2:0], locked};
      soft_pipe <= {soft_pipe[SYNC_STAGES-2:0], soft_rst};
    end
  end
  assign locked_s   = lock_pipe[SYNC_STAGES-1];
  assign soft_rst_s = soft_pipe[SYNC_STAGES-1];

  // Lowest requesting channel and the mask of it and everything above it.
  always_comb begin
    low_k    = '0;
    clr_mask = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (soft_rst_s[i]) low_k = IDX_W'(i);
    end
    for (int i = 0; i < N_CH; i++) begin
      clr_mask[i] = (i >= int'(low_k));
    end
  end

  assign idx_inc = idx + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    idx_n   = idx;
    rst_n_n = rst_n_out;
    done_n  = seq_done;
    case (state)
      WAIT_LOCK: begin
        rst_n_n = '0;
        done_n  = 1'b0;
        idx_n   = '0;
        if (locked_s) begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          rst_n_n[0] = 1'b1;
          cnt_n      = '0;
          idx_n      = '0;
          if (N_CH == 1) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (cnt == STEP_LAST) begin
          cnt_n = '0;
          // After a soft reset idx points at a channel still held low.
          if (!rst_n_out[idx]) begin
            rst_n_n[idx] = 1'b1;
            if (idx == LAST_IDX) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            idx_n            = idx_inc;
            rst_n_n[idx_inc] = 1'b1;
            if (idx_inc == LAST_IDX) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
        end
      end
      DONE: begin
      end
      default: state_n = WAIT_LOCK;
    endcase

    if ((state == RELEASE || state == DONE) && (|soft_rst_s)) begin
      rst_n_n = rst_n_out & ~clr_mask;
      done_n  = 1'b0;
      state_n = RELEASE;
      idx_n   = (low_k < idx) ? low_k : idx;
      cnt_n   = '0;
    end

    if (state != WAIT_LOCK && !locked_s) begin
      state_n = WAIT_LOCK;
      rst_n_n = '0;
      done_n  = 1'b0;
      idx_n   = '0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      rst_n_out <= rst_n_n;
      seq_done  <= done_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen with N_CH=4, HOLD_CYC=8, STEP_CYC=4, SYNC_STAGES=2.
module tb_reset_seq_gen;

  logic       clk = 1'b0;
  logic       g_resetn;
  logic       locked;
  logic [3:0] soft_rst;
  logic [3:0] rst_n_out;
  logic       seq_done;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  reset_seq_gen #(
    .N_CH(4), .CNT_W(8), .HOLD_CYC(8), .STEP_CYC(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .g_resetn(g_resetn), .locked(locked), .soft_rst(soft_rst),
    .rst_n_out(rst_n_out), .seq_done(seq_done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    g_resetn = 1'b1;
    locked   = 1'b1;
    soft_rst = 4'b0000;
    #1 g_resetn = 1'b0;

    // Power-up
    tick(5);
    chk("rst_out", 32'(rst_n_out), 32'h0);
    chk("rst_done", 32'(seq_done), 32'h0);
    chk("rst_state", 32'(state_o), 32'h0);
    g_resetn = 1'b1;
    tick(4);  chk("pre_hold_state", 32'(state_o), 32'h0);
    tick(1);  chk("hold_T_state", 32'(state_o), 32'h1);
    tick(7);  chk("hold_T7_out", 32'(rst_n_out), 32'h0);
    tick(1);  chk("T8_out", 32'(rst_n_out), 32'h1);
              chk("T8_state", 32'(state_o), 32'h2);
    tick(3);  chk("T11_out", 32'(rst_n_out), 32'h1);
    tick(1);  chk("T12_out", 32'(rst_n_out), 32'h3);
    tick(4);  chk("T16_out", 32'(rst_n_out), 32'h7);
              chk("T16_done", 32'(seq_done), 32'h0);
    tick(4);  chk("T20_out", 32'(rst_n_out), 32'hF);
              chk("T20_done", 32'(seq_done), 32'h1);
              chk("T20_state", 32'(state_o), 32'h3);
    tick(3);

    // One-cycle lock drop in DONE
    locked = 1'b0;
    tick(1);  locked = 1'b1;
    tick(1);  chk("lock2_out", 32'(rst_n_out), 32'hF);
              chk("lock2_state", 32'(state_o), 32'h3);
    tick(1);  chk("lock3_out", 32'(rst_n_out), 32'h0);
              chk("lock3_state", 32'(state_o), 32'h0);
              chk("lock3_done", 32'(seq_done), 32'h0);
    tick(1);  chk("relock_hold", 32'(state_o), 32'h1);
    tick(8);  chk("relock_T8_out", 32'(rst_n_out), 32'h1);
    tick(12); chk("relock_T20_out", 32'(rst_n_out), 32'hF);
              chk("relock_T20_done", 32'(seq_done), 32'h1);
    tick(2);

    // Soft reset pulse on ch2
    soft_rst = 4'b0100;
    tick(1);  soft_rst = 4'b0000;
    tick(1);  chk("s2_pre_out", 32'(rst_n_out), 32'hF);
    tick(1);  chk("s2_F_out", 32'(rst_n_out), 32'h3);
              chk("s2_F_done", 32'(seq_done), 32'h0);
              chk("s2_F_state", 32'(state_o), 32'h2);
    tick(3);  chk("s2_F3_out", 32'(rst_n_out), 32'h3);
    tick(1);  chk("s2_F4_out", 32'(rst_n_out), 32'h7);
    tick(4);  chk("s2_F8_out", 32'(rst_n_out), 32'hF);
              chk("s2_F8_done", 32'(seq_done), 32'h1);
              chk("s2_F8_state", 32'(state_o), 32'h3);

    // Two simultaneous requests, lowest (ch1) wins; held for several cycles
    soft_rst = 4'b1010;
    tick(3);  chk("s13_out", 32'(rst_n_out), 32'h1);
              chk("s13_state", 32'(state_o), 32'h2);
              chk("s13_done", 32'(seq_done), 32'h0);
    tick(5);  chk("s13_held_out", 32'(rst_n_out), 32'h1);
    soft_rst = 4'b0000;
    tick(5);  chk("s13_F3_out", 32'(rst_n_out), 32'h1);
    tick(1);  chk("s13_F4_out", 32'(rst_n_out), 32'h3);
    tick(8);  chk("s13_F12_out", 32'(rst_n_out), 32'hF);
              chk("s13_F12_done", 32'(seq_done), 32'h1);

    // Soft reset of ch0 then async global reset mid-RELEASE at idx=2
    soft_rst = 4'b0001;
    tick(1);  soft_rst = 4'b0000;
    tick(2);  chk("s0_F_out", 32'(rst_n_out), 32'h0);
              chk("s0_F_state", 32'(state_o), 32'h2);
    tick(4);  chk("s0_F4_out", 32'(rst_n_out), 32'h1);
    tick(4);  chk("s0_F8_out", 32'(rst_n_out), 32'h3);
    tick(4);  chk("s0_F12_out", 32'(rst_n_out), 32'h7);
    tick(1);
    @(posedge clk);
    #2 g_resetn = 1'b0;
    #1;
    chk("async_out", 32'(rst_n_out), 32'h0);
    chk("async_state", 32'(state_o), 32'h0);
    chk("async_done", 32'(seq_done), 32'h0);
    tick(3);  chk("async_hold_out", 32'(rst_n_out), 32'h0);
    g_resetn = 1'b1;
    tick(5);  chk("rerun_hold", 32'(state_o), 32'h1);
    tick(20); chk("rerun_out", 32'(rst_n_out), 32'hF);
              chk("rerun_state", 32'(state_o), 32'h3);

    // Lock loss and soft request together: lock loss wins
    locked   = 1'b0;
    soft_rst = 4'b0010;
    tick(2);  chk("both_pre_out", 32'(rst_n_out), 32'hF);
    tick(1);  chk("both_state", 32'(state_o), 32'h0);
              chk("both_out", 32'(rst_n_out), 32'h0);
    tick(3);  chk("both_stay_state", 32'(state_o), 32'h0);
              chk("both_stay_out", 32'(rst_n_out), 32'h0);

    // Request held through HOLD is ignored there, then pins idx 0 in RELEASE
    locked = 1'b1;
    tick(3);  chk("hs_hold", 32'(state_o), 32'h1);
    tick(8);  chk("hs_T8_out", 32'(rst_n_out), 32'h1);
              chk("hs_T8_state", 32'(state_o), 32'h2);
    tick(6);  chk("hs_held_out", 32'(rst_n_out), 32'h1);
    soft_rst = 4'b0000;
    tick(5);  chk("hs_F3_out", 32'(rst_n_out), 32'h1);
    tick(1);  chk("hs_F4_out", 32'(rst_n_out), 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
